monopulse_accumulator: RTL and testbench

MONOPULSE_ACCUMULATOR -- requirements
Module: monopulse_accumulator

---
 rtl/monopulse_accumulator.sv | 126 ++++++++++++
 tb/tb_monopulse_accumulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/monopulse_accumulator.sv
// Windowed sum/difference integrator feeding the monopulse divider: accumulates
// A+B and A-B over 2^WINDOW_LOG2 accepted sample pairs, then holds the result
// until the downstream stage takes it. Optional macro MONOPULSE_ACC_DROP_CNT_EN
// enables a saturating count of samples offered while not ready.
module monopulse_accumulator #(
  parameter int IN_SIZE     = 16,
  parameter int DATA_SIZE   = 64,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [IN_SIZE-1:0]   i_chan_a,
  input  logic [IN_SIZE-1:0]   i_chan_b,
  output logic                 o_ready,
  output logic [DATA_SIZE-1:0] o_reference,
  output logic [DATA_SIZE-1:0] o_error,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [15:0]          o_drop_count
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [WINDOW_LOG2-1:0] LAST_COUNT = {WINDOW_LOG2{1'b1}};

  logic [0:0]             r_state;
  logic [WINDOW_LOG2-1:0] r_count;
  logic [DATA_SIZE-1:0]   r_sum;
  logic [DATA_SIZE-1:0]   r_diff;
  logic [DATA_SIZE-1:0]   r_reference;
  logic [DATA_SIZE-1:0]   r_error;
  logic                   r_valid;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_last;
  logic [DATA_SIZE-1:0]   w_a_ext;
  logic [DATA_SIZE-1:0]   w_b_ext;
  logic [DATA_SIZE-1:0]   w_sum_next;
  logic [DATA_SIZE-1:0]   w_diff_next;

  // Sign-extend before add/subtract so the pair sum and difference never truncate.
  assign w_a_ext     = {{(DATA_SIZE-IN_SIZE){i_chan_a[IN_SIZE-1]}}, i_chan_a};
  assign w_b_ext     = {{(DATA_SIZE-IN_SIZE){i_chan_b[IN_SIZE-1]}}, i_chan_b};
  assign w_sum_next  = r_sum + (w_a_ext + w_b_ext);
  assign w_diff_next = r_diff + (w_a_ext - w_b_ext);

  // Ready is withheld during reset cycles so nothing is accepted then.
  always_comb begin
    w_ready = 1'b0;
    if (!i_reset && (r_state == ST_ACCUM)) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
  end

  assign w_accept = i_valid && w_ready;
  assign w_last   = w_accept && (r_count == LAST_COUNT);

  // Window state machine, accumulators and result registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_ACCUM;
      r_count     <= {WINDOW_LOG2{1'b0}};
      r_sum       <= {DATA_SIZE{1'b0}};
      r_diff      <= {DATA_SIZE{1'b0}};
      r_reference <= {DATA_SIZE{1'b0}};
      r_error     <= {DATA_SIZE{1'b0}};
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_count <= r_count + WINDOW_LOG2'(1);
            if (w_last) begin
              r_reference <= w_sum_next;
              r_error     <= w_diff_next;
              r_sum       <= {DATA_SIZE{1'b0}};
              r_diff      <= {DATA_SIZE{1'b0}};
              r_valid     <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_sum  <= w_sum_next;
              r_diff <= w_diff_next;
            end
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_ACCUM;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign o_ready     = w_ready;
  assign o_reference = r_reference;
  assign o_error     = r_error;
  assign o_valid     = r_valid;

`ifdef MONOPULSE_ACC_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Saturating count of samples offered while the block could not take them.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_drop_count <= 16'd0;
    end else if (i_valid && !w_ready && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_drop_count = r_drop_count;
`else
  assign o_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_monopulse_accumulator.sv
// Self-checking bench for monopulse_accumulator (N=4): directed scenarios plus
// randomized traffic against a window-list reference model.
module tb_monopulse_accumulator;

  localparam int IN_SIZE     = 16;
  localparam int DATA_SIZE   = 64;
  localparam int WINDOW_LOG2 = 2;
  localparam int N           = 4;

  logic                 i_clock;
  logic                 i_reset;
  logic                 i_valid;
  logic [IN_SIZE-1:0]   i_chan_a;
  logic [IN_SIZE-1:0]   i_chan_b;
  logic                 o_ready;
  logic [DATA_SIZE-1:0] o_reference;
  logic [DATA_SIZE-1:0] o_error;
  logic                 o_valid;
  logic                 i_ready;
  logic [15:0]          o_drop_count;

  monopulse_accumulator #(
    .IN_SIZE(IN_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .WINDOW_LOG2(WINDOW_LOG2)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_chan_a(i_chan_a),
    .i_chan_b(i_chan_b),
    .o_ready(o_ready),
    .o_reference(o_reference),
    .o_error(o_error),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_drop_count(o_drop_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

`ifdef MONOPULSE_ACC_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open window, plus the held result.
  int     win_a[$];
  int     win_b[$];
  bit     m_pending = 1'b0;
  longint m_ref     = 0;
  longint m_err     = 0;
  int     m_drop    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input bit rst, input bit v, input int a, input int b, input bit rdy);
    longint s;
    longint d;
    if (rst) begin
      win_a.delete();
      win_b.delete();
      m_pending = 1'b0;
      m_ref     = 0;
      m_err     = 0;
      m_drop    = 0;
    end else if (m_pending) begin
      if (v && DROP_EN && m_drop < 65535) m_drop++;
      if (rdy) m_pending = 1'b0;
    end else if (v) begin
      win_a.push_back(a);
      win_b.push_back(b);
      if (win_a.size() == N) begin
        s = 0;
        d = 0;
        foreach (win_a[k]) begin
          s += longint'(win_a[k]) + longint'(win_b[k]);
          d += longint'(win_a[k]) - longint'(win_b[k]);
        end
        m_ref     = s;
        m_err     = d;
        m_pending = 1'b1;
        win_a.delete();
        win_b.delete();
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input int a, input int b, input bit rdy);
    i_reset  = rst;
    i_valid  = v;
    i_chan_a = a[IN_SIZE-1:0];
    i_chan_b = b[IN_SIZE-1:0];
    i_ready  = rdy;
    #1;
    check_val("ready", 64'(o_ready), 64'(!rst && !m_pending));
    @(posedge i_clock);
    model_clock(rst, v, a, b, rdy);
    #1;
    check_val("valid", 64'(o_valid), 64'(m_pending));
    check_val("reference", o_reference, 64'(m_ref));
    check_val("error", o_error, 64'(m_err));
    check_val("drop", 64'(o_drop_count), 64'(m_drop));
  endtask

  initial begin
    int a;
    int b;
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_chan_a = '0;
    i_chan_b = '0;
    i_ready  = 1'b0;

    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 3, 3, 1'b1);
    check_val("rst_ref", o_reference, 64'd0);
    check_val("rst_valid", 64'(o_valid), 64'd0);

    // Four samples A=10,B=2.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 10, 2, 1'b0);
    check_val("w1_valid", 64'(o_valid), 64'd1);
    check_val("w1_ref", o_reference, 64'd48);
    check_val("w1_err", o_error, 64'd32);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check_val("w1_done", 64'(o_valid), 64'd0);
    check_val("w1_keep", o_reference, 64'd48);

    // Negative values, then stall with samples offered while held.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, -5, 3, 1'b0);
    check_val("w2_ref", o_reference, 64'hFFFF_FFFF_FFFF_FFF8);
    check_val("w2_err", o_error, 64'hFFFF_FFFF_FFFF_FFE0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 77, 11, 1'b0);
    check_val("stall_ref", o_reference, 64'hFFFF_FFFF_FFFF_FFF8);
    check_val("stall_drop", 64'(o_drop_count), DROP_EN ? 64'd5 : 64'd0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check_val("stall_release", 64'(o_valid), 64'd0);

    // Partial window discarded by reset.
    step(1'b0, 1'b1, 100, 0, 1'b0);
    step(1'b0, 1'b1, 100, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1, 1, 1'b0);
    check_val("w3_ref", o_reference, 64'd8);
    check_val("w3_err", o_error, 64'd0);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Gapped input.
    for (int i = 0; i < 8; i++) step(1'b0, (i % 2) == 0, 7, -7, 1'b0);
    check_val("w4_ref", o_reference, 64'd0);
    check_val("w4_err", o_error, 64'd56);
    step(1'b0, 1'b0, 0, 0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, a, b,
           $urandom_range(0, 9) < 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
